// File: rtl/mem_ctrl_if.sv
// Bus bundle between a fetch/load-store requester pair, the byte-wide memory and mem_ctrl.
// master = requesters plus memory; slave = the controller.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [2:0]  ls_size;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        busy;

    modport master (
        output if_req, if_addr, ls_req, ls_wr, ls_addr, ls_size, ls_wdata, mem_din,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr, busy
    );

    modport slave (
        input  if_req, if_addr, ls_req, ls_wr, ls_addr, ls_size, ls_wdata, mem_din,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr, busy
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store requests
// onto a memory with one cycle of read latency; all bus outputs come straight from flops.
module mem_ctrl #(
    parameter int MAX_LS_RUN = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);
    localparam int RUN_W = $clog2(MAX_LS_RUN + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_LS_RUN);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t           state_reg, state_next;
    logic [RUN_W-1:0] run_reg, run_next;
    logic [31:0]      addr_reg, addr_next;
    logic [2:0]       n_reg, n_next;
    logic             src_reg, src_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic [2:0]       cnt_reg, cnt_next;
    logic [31:0]      asm_reg, asm_next;
    logic [31:0]      mem_a_reg, mem_a_next;
    logic             mem_wr_reg, mem_wr_next;
    logic [7:0]       mem_dout_reg, mem_dout_next;
    logic             if_done_reg, if_done_next;
    logic             ls_done_reg, ls_done_next;
    logic [31:0]      if_data_reg, if_data_next;
    logic [31:0]      ls_rdata_reg, ls_rdata_next;

    logic [2:0]  step;
    logic [1:0]  rd_lane;
    logic [31:0] step_addr;
    logic [31:0] rd_merge;
    logic [7:0]  wr_lane [4];
    logic [2:0]  ls_n;
    logic        gate_open;
    logic        grant_if;
    logic        grant_ls;

    // cnt_reg counts edges since the grant edge, so step is the index of the coming edge.
    assign step      = cnt_reg + 3'd1;
    assign rd_lane   = 2'(step - 3'd2);
    assign step_addr = addr_reg + {29'd0, step};
    assign ls_n      = (bus.ls_size >= 3'd1 && bus.ls_size <= 3'd4) ? bus.ls_size : 3'd4;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wr_lane[gi]           = wdata_reg[8*gi +: 8];
        assign rd_merge[8*gi +: 8]   = (rd_lane == 2'(gi)) ? bus.mem_din : asm_reg[8*gi +: 8];
    end

    // The done cycle is a mandatory gap: no grant at all, which also keeps the
    // just-finished requester's still-high req from being taken twice.
    assign gate_open = !if_done_reg && !ls_done_reg;
    assign grant_if  = gate_open && bus.if_req && (!bus.ls_req || run_reg == RUN_MAX);
    assign grant_ls  = gate_open && bus.ls_req && !grant_if;

    always_comb begin
        state_next    = state_reg;
        run_next      = run_reg;
        addr_next     = addr_reg;
        n_next        = n_reg;
        src_next      = src_reg;
        wdata_next    = wdata_reg;
        cnt_next      = cnt_reg;
        asm_next      = asm_reg;
        mem_a_next    = mem_a_reg;
        mem_wr_next   = mem_wr_reg;
        mem_dout_next = mem_dout_reg;
        if_done_next  = 1'b0;
        ls_done_next  = 1'b0;
        if_data_next  = if_data_reg;
        ls_rdata_next = ls_rdata_reg;

        case (state_reg)
            IDLE: begin
                mem_a_next  = 32'd0;
                mem_wr_next = 1'b0;
                if (grant_if) begin
                    addr_next  = bus.if_addr;
                    n_next     = 3'd4;
                    src_next   = 1'b0;
                    cnt_next   = 3'd0;
                    asm_next   = 32'd0;
                    run_next   = '0;
                    mem_a_next = bus.if_addr;
                    state_next = RD;
                end else if (grant_ls) begin
                    addr_next   = bus.ls_addr;
                    n_next      = ls_n;
                    src_next    = 1'b1;
                    wdata_next  = bus.ls_wdata;
                    cnt_next    = 3'd0;
                    asm_next    = 32'd0;
                    run_next    = (run_reg == RUN_MAX) ? run_reg : run_reg + 1'b1;
                    mem_a_next  = bus.ls_addr;
                    mem_wr_next = bus.ls_wr;
                    if (bus.ls_wr) begin
                        mem_dout_next = bus.ls_wdata[7:0];
                        // A single-byte store completes on its grant edge.
                        if (ls_n == 3'd1) ls_done_next = 1'b1;
                        else              state_next   = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                cnt_next    = step;
                mem_wr_next = 1'b0;
                mem_a_next  = (step < n_reg) ? step_addr : 32'd0;
                if (step >= 3'd2) begin
                    if (step == n_reg + 3'd1) begin
                        state_next = IDLE;
                        if (src_reg) begin
                            ls_done_next  = 1'b1;
                            ls_rdata_next = rd_merge;
                        end else begin
                            if_done_next = 1'b1;
                            if_data_next = rd_merge;
                        end
                    end else begin
                        asm_next = rd_merge;
                    end
                end
            end
            WR: begin
                cnt_next      = step;
                mem_a_next    = step_addr;
                mem_wr_next   = 1'b1;
                mem_dout_next = wr_lane[step[1:0]];
                if (step == n_reg - 3'd1) begin
                    ls_done_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            run_reg      <= '0;
            addr_reg     <= 32'd0;
            n_reg        <= 3'd0;
            src_reg      <= 1'b0;
            wdata_reg    <= 32'd0;
            cnt_reg      <= 3'd0;
            asm_reg      <= 32'd0;
            mem_a_reg    <= 32'd0;
            mem_wr_reg   <= 1'b0;
            mem_dout_reg <= 8'd0;
            if_done_reg  <= 1'b0;
            ls_done_reg  <= 1'b0;
            if_data_reg  <= 32'd0;
            ls_rdata_reg <= 32'd0;
        end else if (rdy) begin
            state_reg    <= state_next;
            run_reg      <= run_next;
            addr_reg     <= addr_next;
            n_reg        <= n_next;
            src_reg      <= src_next;
            wdata_reg    <= wdata_next;
            cnt_reg      <= cnt_next;
            asm_reg      <= asm_next;
            mem_a_reg    <= mem_a_next;
            mem_wr_reg   <= mem_wr_next;
            mem_dout_reg <= mem_dout_next;
            if_done_reg  <= if_done_next;
            ls_done_reg  <= ls_done_next;
            if_data_reg  <= if_data_next;
            ls_rdata_reg <= ls_rdata_next;
        end
    end

    assign bus.if_done  = if_done_reg;
    assign bus.if_data  = if_data_reg;
    assign bus.ls_done  = ls_done_reg;
    assign bus.ls_rdata = ls_rdata_reg;
    assign bus.mem_a    = mem_a_reg;
    assign bus.mem_wr   = mem_wr_reg;
    assign bus.mem_dout = mem_dout_reg;
    assign bus.busy     = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboarded bench for mem_ctrl: requester tasks push expected results from a
// byte-array reference memory; a negedge monitor pops and compares on every done pulse.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    mem_ctrl_if bus();

    mem_ctrl #(.MAX_LS_RUN(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  dut_ram [logic [31:0]];
    logic [7:0]  ref_ram [logic [31:0]];
    logic [31:0] exp_if_q [$];
    logic [31:0] exp_ls_q [$];
    logic [7:0]  order_log [$];
    logic [31:0] last_ld = 32'd0;
    logic [31:0] e;
    logic        prev_if = 1'b0;
    logic        prev_ls = 1'b0;
    logic [7:0]  wb [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0]  exp_order [10] = '{"L", "L", "L", "L", "I", "L", "L", "L", "L", "I"};

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return {a[3:0], a[7:4]} ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_ram.exists(a)) return ref_ram[a];
        return init_byte(a);
    endfunction

    // Memory with one cycle of registered read latency; it stalls with rdy like the rest of the system.
    always @(posedge clk) begin
        if (rdy) begin
            if (bus.mem_wr) dut_ram[bus.mem_a] = bus.mem_dout;
            bus.mem_din <= dut_ram.exists(bus.mem_a) ? dut_ram[bus.mem_a] : init_byte(bus.mem_a);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk_zero_all(input string tag);
        chk({tag, "_if_done"},  32'(bus.if_done), 32'd0);
        chk({tag, "_ls_done"},  32'(bus.ls_done), 32'd0);
        chk({tag, "_if_data"},  bus.if_data, 32'd0);
        chk({tag, "_ls_rdata"}, bus.ls_rdata, 32'd0);
        chk({tag, "_mem_dout"}, 32'(bus.mem_dout), 32'd0);
        chk({tag, "_mem_a"},    bus.mem_a, 32'd0);
        chk({tag, "_mem_wr"},   32'(bus.mem_wr), 32'd0);
        chk({tag, "_busy"},     32'(bus.busy), 32'd0);
    endtask

    function automatic logic [31:0] if_expect(input logic [31:0] a);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = ref_rd(a + 32'(k));
        return v;
    endfunction

    // Applies the reference rules for one LS op and returns the ls_rdata expected at its done.
    function automatic logic [31:0] ls_expect(input logic wr, input logic [2:0] size,
                                              input logic [31:0] a, input logic [31:0] wd);
        int n = (size >= 3'd1 && size <= 3'd4) ? int'(size) : 4;
        logic [31:0] v = 32'd0;
        if (wr) begin
            for (int k = 0; k < n; k++) ref_ram[a + 32'(k)] = wd[8*k +: 8];
            return last_ld;
        end
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_rd(a + 32'(k));
        last_ld = v;
        return v;
    endfunction

    task automatic do_if(input logic [31:0] a, input bit keep);
        int n = 0;
        exp_if_q.push_back(if_expect(a));
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.if_done && n < 300);
        if (!bus.if_done) begin
            checks++;
            errors++;
            $display("FAIL if_timeout addr=%h cycles=%0d required=done", a, n);
        end
        if (!keep) bus.if_req = 1'b0;
    endtask

    task automatic do_ls(input logic wr, input logic [2:0] size, input logic [31:0] a,
                         input logic [31:0] wd, input bit keep);
        int n = 0;
        exp_ls_q.push_back(ls_expect(wr, size, a, wd));
        bus.ls_wr    = wr;
        bus.ls_size  = size;
        bus.ls_addr  = a;
        bus.ls_wdata = wd;
        bus.ls_req   = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ls_done && n < 300);
        if (!bus.ls_done) begin
            checks++;
            errors++;
            $display("FAIL ls_timeout addr=%h cycles=%0d required=done", a, n);
        end
        if (!keep) bus.ls_req = 1'b0;
    endtask

    task automatic wait_done_if();
        int n = 0;
        while (!bus.if_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.if_done) begin
            errors++;
            $display("FAIL if_restart_timeout got=no_done required=done");
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.if_done) begin
                order_log.push_back("I");
                checks++;
                if (exp_if_q.size() == 0) begin
                    errors++;
                    $display("FAIL if_unexpected_done got=%h expected=none", bus.if_data);
                end else begin
                    e = exp_if_q.pop_front();
                    if (bus.if_data !== e) begin
                        errors++;
                        $display("FAIL if_data got=%h expected=%h", bus.if_data, e);
                    end
                end
                checks++;
                if (prev_if) begin
                    errors++;
                    $display("FAIL if_done_width got=2+ cycles expected=1");
                end
            end
            if (bus.ls_done) begin
                order_log.push_back("L");
                checks++;
                if (exp_ls_q.size() == 0) begin
                    errors++;
                    $display("FAIL ls_unexpected_done got=%h expected=none", bus.ls_rdata);
                end else begin
                    e = exp_ls_q.pop_front();
                    if (bus.ls_rdata !== e) begin
                        errors++;
                        $display("FAIL ls_rdata got=%h expected=%h", bus.ls_rdata, e);
                    end
                end
                checks++;
                if (prev_ls) begin
                    errors++;
                    $display("FAIL ls_done_width got=2+ cycles expected=1");
                end
            end
        end
        prev_if = bus.if_done;
        prev_ls = bus.ls_done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.if_req = 1'b0;  bus.if_addr = 32'd0;
        bus.ls_req = 1'b0;  bus.ls_wr = 1'b0;  bus.ls_addr = 32'd0;
        bus.ls_size = 3'd0; bus.ls_wdata = 32'd0;
        dut_ram[32'h1000] = 8'h13; dut_ram[32'h1001] = 8'h05;
        dut_ram[32'h1002] = 8'h10; dut_ram[32'h1003] = 8'h00;
        dut_ram[32'h20]   = 8'hAB; dut_ram[32'h21]   = 8'hCD;
        ref_ram = dut_ram;

        repeat (3) @(negedge clk);
        chk_zero_all("reset");
        rst = 1'b0;

        // Fetch at 0x1000: four addresses, done after E5.
        exp_if_q.push_back(if_expect(32'h1000));
        bus.if_addr = 32'h1000;
        bus.if_req  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("if_mem_a_E%0d", k), bus.mem_a, (k < 4) ? 32'h1000 + 32'(k) : 32'd0);
            chk($sformatf("if_mem_wr_E%0d", k), 32'(bus.mem_wr), 32'd0);
            chk($sformatf("if_done_E%0d", k), 32'(bus.if_done), (k == 5) ? 32'd1 : 32'd0);
            if (k == 0) chk("if_busy_E0", 32'(bus.busy), 32'd1);
        end
        chk("if_data_literal", bus.if_data, 32'h00100513);
        bus.if_req = 1'b0;
        @(negedge clk);

        // Two-byte load at 0x20: done after E3.
        exp_ls_q.push_back(ls_expect(1'b0, 3'd2, 32'h20, 32'd0));
        bus.ls_wr = 1'b0; bus.ls_size = 3'd2; bus.ls_addr = 32'h20; bus.ls_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) chk($sformatf("ld2_mem_a_E%0d", k), bus.mem_a, (k < 2) ? 32'h20 + 32'(k) : 32'd0);
            chk($sformatf("ld2_done_E%0d", k), 32'(bus.ls_done), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("ld2_rdata_literal", bus.ls_rdata, 32'h0000CDAB);
        bus.ls_req = 1'b0;
        @(negedge clk);

        // Four-byte store at 0x40: done after E3, mem_wr low after E4.
        exp_ls_q.push_back(ls_expect(1'b1, 3'd4, 32'h40, 32'hDEADBEEF));
        bus.ls_wr = 1'b1; bus.ls_size = 3'd4; bus.ls_addr = 32'h40;
        bus.ls_wdata = 32'hDEADBEEF; bus.ls_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("st4_mem_a_E%0d", k), bus.mem_a, (k < 4) ? 32'h40 + 32'(k) : 32'd0);
            chk($sformatf("st4_mem_wr_E%0d", k), 32'(bus.mem_wr), (k < 4) ? 32'd1 : 32'd0);
            if (k < 4) chk($sformatf("st4_mem_dout_E%0d", k), 32'(bus.mem_dout), 32'(wb[k]));
            chk($sformatf("st4_done_E%0d", k), 32'(bus.ls_done), (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) bus.ls_req = 1'b0;
        end
        chk("st4_rdata_kept", bus.ls_rdata, 32'h0000CDAB);
        do_ls(1'b0, 3'd4, 32'h40, 32'd0, 1'b0);
        chk("st4_readback", bus.ls_rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Reset sampled at E2 of a fetch aborts it; the held request then restarts.
        exp_if_q.push_back(if_expect(32'h1010));
        bus.if_addr = 32'h1010;
        bus.if_req  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_ld = 32'd0;
        @(negedge clk);
        chk_zero_all("midrst");
        rst = 1'b0;
        @(negedge clk);
        wait_done_if();
        bus.if_req = 1'b0;
        @(negedge clk);

        // Out-of-range sizes move four bytes; single-byte and wrapping stores.
        do_ls(1'b0, 3'd0, 32'h50, 32'd0, 1'b0);
        do_ls(1'b0, 3'd7, 32'h60, 32'd0, 1'b0);
        do_ls(1'b1, 3'd1, 32'h80, 32'h000000A5, 1'b0);
        do_ls(1'b0, 3'd1, 32'h80, 32'd0, 1'b0);
        do_ls(1'b1, 3'd4, 32'hFFFFFFFE, 32'h01020304, 1'b0);
        do_ls(1'b0, 3'd4, 32'hFFFFFFFE, 32'd0, 1'b0);
        @(negedge clk);

        // rdy low for three cycles in the middle of a store.
        exp_ls_q.push_back(ls_expect(1'b1, 3'd4, 32'h70, 32'h11223344));
        bus.ls_wr = 1'b1; bus.ls_size = 3'd4; bus.ls_addr = 32'h70;
        bus.ls_wdata = 32'h11223344; bus.ls_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("stall_pre_mem_a", bus.mem_a, 32'h71);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall_mem_a_%0d", k), bus.mem_a, 32'h71);
            chk($sformatf("stall_mem_dout_%0d", k), 32'(bus.mem_dout), 32'h33);
            chk($sformatf("stall_mem_wr_%0d", k), 32'(bus.mem_wr), 32'd1);
            chk($sformatf("stall_done_%0d", k), 32'(bus.ls_done), 32'd0);
        end
        rdy = 1'b1;
        for (int n = 0; n < 20 && !bus.ls_done; n++) @(negedge clk);
        chk("stall_done_seen", 32'(bus.ls_done), 32'd1);
        bus.ls_req = 1'b0;
        do_ls(1'b0, 3'd4, 32'h70, 32'd0, 1'b0);
        @(negedge clk);

        // Both requesters held continuously from reset: fetch gets every fifth slot.
        rst = 1'b1;
        last_ld = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        order_log.delete();
        fork
            for (int i = 0; i < 2; i++) do_if(32'h1020 + 32'(16 * i), i != 1);
            for (int i = 0; i < 8; i++) do_ls(1'b0, 3'd1, 32'h90 + 32'(i), 32'd0, i != 7);
        join
        @(negedge clk);
        chk("order_len", 32'(order_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < order_log.size(); i++)
            chk($sformatf("order_%0d", i), 32'(order_log[i]), 32'(exp_order[i]));

        // Randomized concurrent traffic.
        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                do_if(32'h1000 + 32'($urandom_range(0, 255)), 1'b0);
            end
            for (int i = 0; i < 40; i++) begin
                logic [31:0] a;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                a = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                                : 32'($urandom_range(0, 255));
                do_ls(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b0);
            end
        join
        repeat (4) @(negedge clk);
        chk("if_queue_empty", 32'(exp_if_q.size()), 32'd0);
        chk("ls_queue_empty", 32'(exp_ls_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
